// File: rtl/serial_pkg.sv
// serial_pkg: shared arbiter FSM encoding, requester-count limits and the
// one-hot winner-select helper used by serial_tx_arbiter.
package serial_pkg;

   localparam int unsigned NumReqMin = 2;
   localparam int unsigned NumReqMax = 8;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StSend
   } arb_state_e;

   // One-hot of the first set bit of req, searching upward from ptr and wrapping
   // at n. With ptr = 0 this is fixed priority, bit 0 highest.
   function automatic logic [NumReqMax-1:0] pick_onehot(
      input logic [NumReqMax-1:0] req,
      input int unsigned          n,
      input int unsigned          ptr
   );
      logic [NumReqMax-1:0] grant;
      logic                 found;
      int unsigned          idx;
      grant = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NumReqMax; i++) begin
         if (i < n) begin
            idx = ptr + i;
            if (idx >= n) begin
               idx = idx - n;
            end
            if (!found && req[idx[2:0]]) begin
               grant[idx[2:0]] = 1'b1;
               found           = 1'b1;
            end
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/serial_tx.sv
// serial_tx: 8N1 UART transmitter. A byte is accepted when i_wr is high while
// idle; o_busy stays high from the start bit through the end of the stop bit.
module serial_tx #(
   parameter int unsigned CLK_FREQ  = 48_000_000,
   parameter int unsigned BAUD_RATE = 115_200
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_wr,
   input  logic [7:0] i_data,
   output logic       o_busy,
   output logic       o_tx
);

   localparam int unsigned ClksPerBit = CLK_FREQ / BAUD_RATE;
   localparam int unsigned CntW       = ($clog2(ClksPerBit) > 0) ? $clog2(ClksPerBit) : 1;

   logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   logic [9:0]      shift_q, shift_d;
   logic            busy_q, busy_d;

   // Next state: load a frame when idle, otherwise shift one bit per baud period.
   always_comb begin
      clk_cnt_d = clk_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      busy_d    = busy_q;
      if (!busy_q) begin
         if (i_wr) begin
            shift_d   = {1'b1, i_data, 1'b0};
            busy_d    = 1'b1;
            clk_cnt_d = '0;
            bit_cnt_d = '0;
         end
      end else if (clk_cnt_q == CntW'(ClksPerBit - 1)) begin
         clk_cnt_d = '0;
         shift_d   = {1'b1, shift_q[9:1]};
         if (bit_cnt_q == 4'd9) begin
            busy_d = 1'b0;
         end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
      end else begin
         clk_cnt_d = clk_cnt_q + 1'b1;
      end
   end

   // State registers; reset aborts any frame in progress.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '1;
         busy_q    <= 1'b0;
      end else begin
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         busy_q    <= busy_d;
      end
   end

   assign o_busy = busy_q;
   assign o_tx   = busy_q ? shift_q[0] : 1'b1;

endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: shares one serial_tx among NUM_REQ byte requesters.
// Define SERIAL_TX_ARB_RR_EN for round-robin arbitration; otherwise requester 0
// has fixed highest priority and no pointer register is built.
module serial_tx_arbiter
   import serial_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 48_000_000,
   parameter int unsigned BAUD_RATE = 115_200,
   parameter int unsigned NUM_REQ   = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [NUM_REQ-1:0]   i_wr,
   input  logic [8*NUM_REQ-1:0] i_data,
   output logic [NUM_REQ-1:0]   o_ack,
   output logic [NUM_REQ-1:0]   o_grant,
   output logic                 o_busy,
   output logic                 o_tx
);

   arb_state_e           state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic [7:0]           byte_q, byte_d;
   logic                 tx_wr;
   logic                 tx_busy;

   logic [NumReqMax-1:0] win_ext;
   logic [2:0]           win_idx;
   logic [NUM_REQ-1:0]   win;
   logic [7:0]           sel_byte;
   int unsigned          ptr_start;

`ifdef SERIAL_TX_ARB_RR_EN
   localparam int unsigned PtrW = ($clog2(NUM_REQ) > 0) ? $clog2(NUM_REQ) : 1;
   logic [PtrW-1:0] ptr_q, ptr_d, ptr_nxt;
`endif

   // Winner select: one-hot from the package helper, then its byte and next pointer.
   always_comb begin
`ifdef SERIAL_TX_ARB_RR_EN
      ptr_start = int unsigned'(ptr_q);
      ptr_nxt   = '0;
`else
      ptr_start = 0;
`endif
      win_ext  = pick_onehot(NumReqMax'(i_wr), NUM_REQ, ptr_start);
      win_idx  = '0;
      for (int k = 0; k < NumReqMax; k++) begin
         if (win_ext[k]) begin
            win_idx = 3'(k);
         end
      end
      win      = '0;
      sel_byte = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (win_idx == 3'(k)) begin
            win[k]   = 1'b1;
            sel_byte = i_data[8*k +: 8];
`ifdef SERIAL_TX_ARB_RR_EN
            ptr_nxt  = (k == NUM_REQ - 1) ? '0 : PtrW'(k + 1);
`endif
         end
      end
   end

   // FSM next state: arbitrate in idle, hand byte to serial_tx, wait for frame end.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ack_d   = '0;
      byte_d  = byte_q;
      tx_wr   = 1'b0;
`ifdef SERIAL_TX_ARB_RR_EN
      ptr_d   = ptr_q;
`endif
      unique case (state_q)
         StIdle: begin
            if ((|i_wr) && !tx_busy) begin
               state_d = StStart;
               grant_d = win;
               ack_d   = win;
               byte_d  = sel_byte;
`ifdef SERIAL_TX_ARB_RR_EN
               ptr_d   = ptr_nxt;
`endif
            end
         end
         StStart: begin
            tx_wr = 1'b1;
            if (tx_busy) begin
               state_d = StSend;
            end
         end
         StSend: begin
            if (!tx_busy) begin
               state_d = StIdle;
               grant_d = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= StIdle;
         grant_q <= '0;
         ack_q   <= '0;
         byte_q  <= '0;
`ifdef SERIAL_TX_ARB_RR_EN
         ptr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         byte_q  <= byte_d;
`ifdef SERIAL_TX_ARB_RR_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   serial_tx #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE)
   ) u_serial_tx (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_wr   (tx_wr),
      .i_data (byte_q),
      .o_busy (tx_busy),
      .o_tx   (o_tx)
   );

   assign o_ack   = ack_q;
   assign o_grant = grant_q;
   assign o_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: expected bytes/acks are queued when stimulus is
// driven and checked by monitors that decode o_tx and o_ack.
module tb_serial_tx_arbiter;

   localparam int unsigned ClkFreq = 1_000_000;
   localparam int unsigned Baud    = 100_000;
   localparam int unsigned NumReq  = 4;
   // Frame start to frame start under continuous demand: 10 bits x 10 clocks,
   // plus SEND exit, idle arbitration and serial_tx accept.
   localparam longint FramePeriod = 103;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  wr = '0;
   logic [31:0] data = '0;
   logic [3:0]  ack;
   logic [3:0]  grant;
   logic        busy;
   logic        tx;

   int          errors = 0;
   int          checks = 0;
   longint      cycle = 0;

   logic [7:0]  exp_byte_q[$];
   int          exp_idx_q[$];
   int          exp_ack_q[$];
   longint      starts[$];

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   serial_tx_arbiter #(
      .CLK_FREQ  (ClkFreq),
      .BAUD_RATE (Baud),
      .NUM_REQ   (NumReq)
   ) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_wr    (wr),
      .i_data  (data),
      .o_ack   (ack),
      .o_grant (grant),
      .o_busy  (busy),
      .o_tx    (tx)
   );

   // Acknowledge monitor: every pulse must match the next expected requester.
   initial begin
      int e;
      forever begin
         @(negedge clk);
         if (!rst && ack !== 4'b0) begin
            checks++;
            if (exp_ack_q.size() == 0) begin
               errors++;
               $display("FAIL ack_unexpected: o_ack=%b, none expected", ack);
            end else begin
               e = exp_ack_q.pop_front();
               if (ack !== (4'b0001 << e)) begin
                  errors++;
                  $display("FAIL ack_order: o_ack=%b, expected %b", ack, 4'b0001 << e);
               end
            end
         end
      end
   end

   // Line monitor: decode 8N1 frames at mid-bit; frames cut by reset are dropped.
   initial begin
      logic [9:0] bits;
      logic [3:0] gnt_seen;
      logic [7:0] eb;
      int         ei;
      bit         aborted;
      forever begin
         @(negedge clk);
         if (!rst && tx === 1'b0) begin
            starts.push_back(cycle);
            aborted  = 1'b0;
            bits     = '0;
            gnt_seen = '0;
            for (int c = 1; c <= 94; c++) begin
               @(negedge clk);
               if (rst) begin
                  aborted = 1'b1;
                  break;
               end
               if (c % 10 == 4) bits[c/10] = tx;
               if (c == 44) gnt_seen = grant;
            end
            if (!aborted) begin
               checks++;
               if (bits[0] !== 1'b0 || bits[9] !== 1'b1) begin
                  errors++;
                  $display("FAIL frame_framing: start=%b stop=%b, expected 0 and 1",
                           bits[0], bits[9]);
               end
               checks++;
               if (exp_byte_q.size() == 0) begin
                  errors++;
                  $display("FAIL frame_unexpected: byte 0x%h sent, none expected", bits[8:1]);
               end else begin
                  eb = exp_byte_q.pop_front();
                  ei = exp_idx_q.pop_front();
                  if (bits[8:1] !== eb) begin
                     errors++;
                     $display("FAIL frame_data: got 0x%h, expected 0x%h", bits[8:1], eb);
                  end
                  checks++;
                  if (gnt_seen !== (4'b0001 << ei)) begin
                     errors++;
                     $display("FAIL frame_grant: o_grant=%b, expected %b",
                              gnt_seen, 4'b0001 << ei);
                  end
               end
            end
         end
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic expect_byte(input int idx, input logic [7:0] b);
      exp_byte_q.push_back(b);
      exp_idx_q.push_back(idx);
      exp_ack_q.push_back(idx);
   endtask

   task automatic wait_ack(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (ack !== 4'b0) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_ack_timeout: no o_ack within 600 cycles, expected a pulse", name);
      end
   endtask

   task automatic wait_drain(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (exp_byte_q.size() == 0 && exp_ack_q.size() == 0 && busy === 1'b0) begin
            done = 1'b1;
            break;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_drain: %0d bytes %0d acks pending busy=%b, expected 0 0 0",
                  name, exp_byte_q.size(), exp_ack_q.size(), busy);
      end
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: o_tx=%b, expected 1", tx); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: o_busy=%b, expected 0", busy); end
      checks++;
      if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack: o_ack=%b, expected 0000", ack); end
      checks++;
      if (grant !== 4'b0) begin
         errors++;
         $display("FAIL reset_grant: o_grant=%b, expected 0000", grant);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_single();
      data[7:0] = 8'h4B;
      expect_byte(0, 8'h4B);
      wr = 4'b0001;
      wait_ack("single");
      wr = 4'b0000;
      wait_drain("single");
   endtask

   task automatic test_back_to_back();
      data = {8'h44, 8'h43, 8'h42, 8'h41};
      starts.delete();
`ifdef SERIAL_TX_ARB_RR_EN
      for (int i = 0; i < 6; i++) expect_byte(i % 4, 8'h41 + 8'(i % 4));
`else
      for (int i = 0; i < 6; i++) expect_byte(0, 8'h41);
`endif
      wr = 4'b1111;
      for (int i = 0; i < 6; i++) wait_ack("b2b");
      wr = 4'b0000;
      wait_drain("b2b");
      checks++;
      if (starts.size() != 6) begin
         errors++;
         $display("FAIL b2b_frames: %0d frames, expected 6", starts.size());
      end else begin
         for (int i = 1; i < 6; i++) begin
            checks++;
            if (starts[i] - starts[i-1] != FramePeriod) begin
               errors++;
               $display("FAIL b2b_gap: frame %0d started %0d cycles after previous, expected %0d",
                        i, starts[i] - starts[i-1], FramePeriod);
            end
         end
      end
   endtask

   task automatic test_withdraw();
      data = {8'h00, 8'hC3, 8'h00, 8'h5A};
      starts.delete();
      expect_byte(0, 8'h5A);
      wr = 4'b0001;
      wait_ack("withdraw");
      wr = 4'b0000;
      repeat (30) @(negedge clk);
      wr[2] = 1'b1;
      repeat (40) @(negedge clk);
      wr[2] = 1'b0;
      wait_drain("withdraw");
      repeat (150) @(negedge clk);
      checks++;
      if (starts.size() != 1) begin
         errors++;
         $display("FAIL withdraw_frames: %0d frames, expected 1", starts.size());
      end
   endtask

   task automatic test_reset_midframe();
      data = {8'h00, 8'h00, 8'h3C, 8'h0F};
      expect_byte(0, 8'h0F);
      wr = 4'b0001;
      wait_ack("midrst");
      wr = 4'b0000;
      // Ack negedge is half a cycle before the start bit: this lands mid data bit 4.
      repeat (55) @(negedge clk);
      checks++;
      if (tx !== 1'b0) begin errors++; $display("FAIL midrst_bit4: o_tx=%b, expected 0", tx); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx: o_tx=%b, expected 1", tx); end
      checks++;
      if (busy !== 1'b0 || grant !== 4'b0) begin
         errors++;
         $display("FAIL midrst_state: o_busy=%b o_grant=%b, expected 0 0000", busy, grant);
      end
      exp_byte_q.delete();
      exp_idx_q.delete();
      repeat (3) @(negedge clk);
      expect_byte(1, 8'h3C);
      wr  = 4'b0010;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (ack !== 4'b0010 || grant !== 4'b0010) begin
         errors++;
         $display("FAIL midrst_first_arb: o_ack=%b o_grant=%b, expected 0010 0010", ack, grant);
      end
      wr = 4'b0000;
      wait_drain("midrst");
   endtask

   task automatic test_data_change();
      data = {8'h00, 8'h00, 8'h00, 8'h55};
      expect_byte(0, 8'h55);
      wr = 4'b0001;
      wait_ack("datachg");
      wr = 4'b0000;
      @(negedge clk);
      data[7:0] = 8'hAA;
      wait_drain("datachg");
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_withdraw();
      test_reset_midframe();
      test_data_change();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
